debug_loader_fsm: RTL and testbench

- Debug-unit front end that sits directly downstream of the UART receiver and upstream of the MIPS pipeline and its instruction memory.
- Consumes received bytes (data plus a one-cycle done strobe) and decodes host commands.
- Assembles 4-byte instruction words, MSB first, and writes them sequentially into instruction memory until the HALT word.
- Then gates the pipeline clock-enable for continuous or single-step execution until the pipeline reports HALT.

---
 rtl/debug_loader_if.sv | 41 ++++
 rtl/debug_loader_fsm.sv | 174 +++++++++++++++++
 tb/tb_debug_loader_fsm.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_loader_if.sv
// Bundles the signals exchanged between the debug loader and its neighbours:
// the UART receive byte stream, the pipeline halt level, the instruction-memory
// write port and the pipeline run/status outputs.
//
// Ports (by modport):
//   master : host/UART side and consumers. Drives i_rx_data, i_rx_done and
//            i_cpu_halted. Observes all o_* signals.
//   slave  : the loader itself. Sees i_* and drives o_*.
//
// Handshake: the receive stream is strobe-only. i_rx_data is meaningful only in
// a cycle where i_rx_done=1. i_rx_done is high for one cycle per byte, and may
// be high on consecutive cycles. There is no ready; the loader accepts every
// strobe in every state. Bytes a state has no use for are dropped.
interface debug_loader_if #(
    parameter int NB_DATA  = 8,
    parameter int NB_INSTR = 32,
    parameter int NB_ADDR  = 8
);
    logic [NB_DATA-1:0]  i_rx_data;
    logic                i_rx_done;
    logic                i_cpu_halted;
    logic                o_imem_we;
    logic [NB_ADDR-1:0]  o_imem_addr;
    logic [NB_INSTR-1:0] o_imem_data;
    logic                o_cpu_en;
    logic                o_load_done;
    logic                o_err_ovf;
    logic [2:0]          o_state;

    modport master (
        output i_rx_data, i_rx_done, i_cpu_halted,
        input  o_imem_we, o_imem_addr, o_imem_data, o_cpu_en,
        input  o_load_done, o_err_ovf, o_state
    );

    modport slave (
        input  i_rx_data, i_rx_done, i_cpu_halted,
        output o_imem_we, o_imem_addr, o_imem_data, o_cpu_en,
        output o_load_done, o_err_ovf, o_state
    );
endinterface

// File: rtl/debug_loader_fsm.sv
// Debug-unit front end between the UART receiver and the MIPS pipeline.
// Decodes host command bytes, assembles MSB-first instruction words into
// sequential instruction-memory writes until the HALT word, then gates the
// pipeline clock enable for continuous or single-step execution until the
// pipeline reports HALT.
//
// Ports:
//   clk      : system clock
//   i_rst_n  : asynchronous active-low reset
//   bus      : debug_loader_if slave modport
//              in : i_rx_data, i_rx_done, i_cpu_halted
//              out: o_imem_we, o_imem_addr, o_imem_data, o_cpu_en,
//                   o_load_done, o_err_ovf, o_state (FSM encoding, debug)
//
// All outputs are registered; a byte strobed in cycle N acts in cycle N+1.
module debug_loader_fsm #(
    parameter int                  NB_DATA   = 8,
    parameter int                  NB_INSTR  = 32,
    parameter int                  NB_ADDR   = 8,
    parameter logic [NB_INSTR-1:0] HALT_WORD = 32'hFFFFFFFF,
    parameter logic [NB_DATA-1:0]  CMD_LOAD  = 8'h01,
    parameter logic [NB_DATA-1:0]  CMD_STEP  = 8'h02,
    parameter logic [NB_DATA-1:0]  CMD_CONT  = 8'h04
) (
    input  logic          clk,
    input  logic          i_rst_n,
    debug_loader_if.slave bus
);

    localparam int NB_BYTES = NB_INSTR / NB_DATA;
    localparam int NB_BCNT  = $clog2(NB_BYTES);
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_BYTES - 1);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_MODE = 3'd2,
        ST_RUN       = 3'd3,
        ST_STEP      = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t                       state_q;
    logic [NB_BCNT-1:0]           byte_cnt_q;
    logic [NB_ADDR-1:0]           word_addr_q;
    // Only the low bytes are kept: the oldest byte of a word is never needed
    // again once the word is complete.
    logic [NB_INSTR-NB_DATA-1:0]  asm_q;
    logic [NB_INSTR-1:0]          word_next;

    logic                         imem_we_q;
    logic [NB_ADDR-1:0]           imem_addr_q;
    logic [NB_INSTR-1:0]          imem_data_q;
    logic                         cpu_en_q;
    logic                         load_done_q;
    logic                         err_ovf_q;

    logic rx_load;
    logic rx_step;
    logic rx_cont;

    always_comb begin
        word_next = {asm_q, bus.i_rx_data};
        rx_load   = bus.i_rx_done && (bus.i_rx_data == CMD_LOAD);
        rx_step   = bus.i_rx_done && (bus.i_rx_data == CMD_STEP);
        rx_cont   = bus.i_rx_done && (bus.i_rx_data == CMD_CONT);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            word_addr_q <= '0;
            asm_q       <= '0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            cpu_en_q    <= 1'b0;
            load_done_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            // Pulse outputs default low; imem_addr/imem_data hold.
            imem_we_q   <= 1'b0;
            load_done_q <= 1'b0;
            cpu_en_q    <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (rx_load) begin
                        state_q     <= ST_LOAD;
                        word_addr_q <= '0;
                        byte_cnt_q  <= '0;
                        asm_q       <= '0;
                    end
                end

                ST_LOAD: begin
                    if (bus.i_rx_done) begin
                        asm_q <= word_next[NB_INSTR-NB_DATA-1:0];
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_q  <= '0;
                            imem_we_q   <= 1'b1;
                            imem_addr_q <= word_addr_q;
                            imem_data_q <= word_next;
                            // Address saturates at the top of memory.
                            if (word_addr_q != LAST_ADDR) begin
                                word_addr_q <= word_addr_q + NB_ADDR'(1);
                            end
                            if (word_next == HALT_WORD) begin
                                load_done_q <= 1'b1;
                                state_q     <= ST_WAIT_MODE;
                            end else if (word_addr_q == LAST_ADDR) begin
                                // Memory full and still no HALT word.
                                err_ovf_q <= 1'b1;
                                state_q   <= ST_WAIT_MODE;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + NB_BCNT'(1);
                        end
                    end
                end

                ST_WAIT_MODE: begin
                    if (rx_cont) begin
                        state_q  <= ST_RUN;
                        cpu_en_q <= 1'b1;
                    end else if (rx_step) begin
                        // The entry byte only selects the mode.
                        state_q <= ST_STEP;
                    end
                end

                ST_RUN: begin
                    if (bus.i_cpu_halted) begin
                        state_q <= ST_DONE;
                    end else begin
                        cpu_en_q <= 1'b1;
                    end
                end

                ST_STEP: begin
                    // Halt has priority over a coincident step byte.
                    if (bus.i_cpu_halted) begin
                        state_q <= ST_DONE;
                    end else if (rx_step) begin
                        cpu_en_q <= 1'b1;
                    end
                end

                ST_DONE: begin
                    if (rx_load) begin
                        state_q     <= ST_LOAD;
                        word_addr_q <= '0;
                        byte_cnt_q  <= '0;
                        asm_q       <= '0;
                        err_ovf_q   <= 1'b0;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_imem_we   = imem_we_q;
    assign bus.o_imem_addr = imem_addr_q;
    assign bus.o_imem_data = imem_data_q;
    assign bus.o_cpu_en    = cpu_en_q;
    assign bus.o_load_done = load_done_q;
    assign bus.o_err_ovf   = err_ovf_q;
    assign bus.o_state     = state_q;

endmodule

// File: tb/tb_debug_loader_fsm.sv
// Directed bench for debug_loader_fsm. Instance dut_a uses the default 8-bit
// word address; dut_b uses a 2-bit address to reach memory-full quickly.
// Inputs change 1 time unit after a rising edge; outputs are read at the same
// point, so after a strobe cycle the registered response is visible.
module tb_debug_loader_fsm;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    debug_loader_if #(.NB_DATA(8), .NB_INSTR(32), .NB_ADDR(8)) ifa ();
    debug_loader_if #(.NB_DATA(8), .NB_INSTR(32), .NB_ADDR(2)) ifb ();

    debug_loader_fsm #(.NB_ADDR(8)) dut_a (.clk(clk), .i_rst_n(rst_n), .bus(ifa));
    debug_loader_fsm #(.NB_ADDR(2)) dut_b (.clk(clk), .i_rst_n(rst_n), .bus(ifb));

    int checks = 0;
    int errors = 0;
    int we_cnt_a = 0;
    int en_cnt_a = 0;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (ifa.o_imem_we === 1'b1) we_cnt_a++;
        if (ifa.o_cpu_en === 1'b1) en_cnt_a++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit to_b, input logic [7:0] b);
        tick();
        if (to_b) begin
            ifb.i_rx_data = b;
            ifb.i_rx_done = 1'b1;
        end else begin
            ifa.i_rx_data = b;
            ifa.i_rx_done = 1'b1;
        end
        tick();
        ifa.i_rx_done = 1'b0;
        ifb.i_rx_done = 1'b0;
    endtask

    task automatic send_word(input bit to_b, input logic [31:0] w);
        send_byte(to_b, w[31:24]);
        send_byte(to_b, w[23:16]);
        send_byte(to_b, w[15:8]);
        send_byte(to_b, w[7:0]);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (ifa.o_imem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0h exp 0", ifa.o_imem_we); end
        checks++; if (ifa.o_imem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %0h exp 0", ifa.o_imem_addr); end
        checks++; if (ifa.o_imem_data !== 32'h0) begin errors++; $display("FAIL rst_data got %0h exp 0", ifa.o_imem_data); end
        checks++; if (ifa.o_cpu_en !== 1'b0) begin errors++; $display("FAIL rst_cpu_en got %0h exp 0", ifa.o_cpu_en); end
        checks++; if (ifa.o_load_done !== 1'b0) begin errors++; $display("FAIL rst_load_done got %0h exp 0", ifa.o_load_done); end
        checks++; if (ifa.o_err_ovf !== 1'b0) begin errors++; $display("FAIL rst_err_ovf got %0h exp 0", ifa.o_err_ovf); end
        checks++; if (ifa.o_state !== 3'd0) begin errors++; $display("FAIL rst_state got %0h exp 0", ifa.o_state); end
        checks++; if (ifb.o_state !== 3'd0) begin errors++; $display("FAIL rst_state_b got %0h exp 0", ifb.o_state); end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        logic [31:0] words [4];
        int w0;
        words = '{32'h2001000F, 32'h20020008, 32'h00221821, 32'hFFFFFFFF};
        w0 = we_cnt_a;
        send_byte(1'b0, 8'h01);
        checks++; if (ifa.o_state !== 3'd1) begin errors++; $display("FAIL load_enter_state got %0h exp 1", ifa.o_state); end
        for (int i = 0; i < 4; i++) begin
            send_word(1'b0, words[i]);
            checks++; if (ifa.o_imem_we !== 1'b1) begin errors++; $display("FAIL load_we[%0d] got %0h exp 1", i, ifa.o_imem_we); end
            checks++; if (ifa.o_imem_addr !== 8'(i)) begin errors++; $display("FAIL load_addr[%0d] got %0h exp %0h", i, ifa.o_imem_addr, i); end
            checks++; if (ifa.o_imem_data !== words[i]) begin errors++; $display("FAIL load_data[%0d] got %0h exp %0h", i, ifa.o_imem_data, words[i]); end
            checks++; if (ifa.o_load_done !== (i == 3)) begin errors++; $display("FAIL load_done[%0d] got %0h exp %0h", i, ifa.o_load_done, (i == 3)); end
            tick();
            checks++; if (ifa.o_imem_we !== 1'b0) begin errors++; $display("FAIL load_we_single[%0d] got %0h exp 0", i, ifa.o_imem_we); end
            checks++; if (ifa.o_imem_data !== words[i]) begin errors++; $display("FAIL load_data_hold[%0d] got %0h exp %0h", i, ifa.o_imem_data, words[i]); end
        end
        checks++; if (ifa.o_load_done !== 1'b0) begin errors++; $display("FAIL load_done_single got %0h exp 0", ifa.o_load_done); end
        checks++; if (ifa.o_state !== 3'd2) begin errors++; $display("FAIL load_exit_state got %0h exp 2", ifa.o_state); end
        checks++; if (ifa.o_err_ovf !== 1'b0) begin errors++; $display("FAIL load_err_ovf got %0h exp 0", ifa.o_err_ovf); end
        checks++; if (we_cnt_a - w0 !== 4) begin errors++; $display("FAIL load_write_count got %0d exp 4", we_cnt_a - w0); end
    endtask

    task automatic test_run();
        bit all_on;
        send_byte(1'b0, 8'h04);
        checks++; if (ifa.o_cpu_en !== 1'b1) begin errors++; $display("FAIL run_en_start got %0h exp 1", ifa.o_cpu_en); end
        checks++; if (ifa.o_state !== 3'd3) begin errors++; $display("FAIL run_state got %0h exp 3", ifa.o_state); end
        all_on = 1'b1;
        repeat (50) begin
            tick();
            if (ifa.o_cpu_en !== 1'b1) all_on = 1'b0;
        end
        checks++; if (all_on !== 1'b1) begin errors++; $display("FAIL run_en_continuous got %0h exp 1", all_on); end
        ifa.i_cpu_halted = 1'b1;
        tick();
        checks++; if (ifa.o_cpu_en !== 1'b0) begin errors++; $display("FAIL run_halt_en got %0h exp 0", ifa.o_cpu_en); end
        checks++; if (ifa.o_state !== 3'd5) begin errors++; $display("FAIL run_halt_state got %0h exp 5", ifa.o_state); end
        ifa.i_cpu_halted = 1'b0;
        send_byte(1'b0, 8'h04);
        tick();
        checks++; if (ifa.o_cpu_en !== 1'b0) begin errors++; $display("FAIL done_cont_en got %0h exp 0", ifa.o_cpu_en); end
        checks++; if (ifa.o_state !== 3'd5) begin errors++; $display("FAIL done_cont_state got %0h exp 5", ifa.o_state); end
    endtask

    task automatic test_step();
        int e0;
        send_byte(1'b0, 8'h01);
        send_word(1'b0, 32'hFFFFFFFF);
        checks++; if (ifa.o_imem_addr !== 8'h00) begin errors++; $display("FAIL reload_addr got %0h exp 0", ifa.o_imem_addr); end
        checks++; if (ifa.o_load_done !== 1'b1) begin errors++; $display("FAIL reload_done got %0h exp 1", ifa.o_load_done); end
        send_byte(1'b0, 8'h02);
        checks++; if (ifa.o_cpu_en !== 1'b0) begin errors++; $display("FAIL step_entry_en got %0h exp 0", ifa.o_cpu_en); end
        checks++; if (ifa.o_state !== 3'd4) begin errors++; $display("FAIL step_state got %0h exp 4", ifa.o_state); end
        e0 = en_cnt_a;
        for (int i = 0; i < 3; i++) begin
            send_byte(1'b0, 8'h02);
            checks++; if (ifa.o_cpu_en !== 1'b1) begin errors++; $display("FAIL step_pulse[%0d] got %0h exp 1", i, ifa.o_cpu_en); end
            tick();
            checks++; if (ifa.o_cpu_en !== 1'b0) begin errors++; $display("FAIL step_pulse_end[%0d] got %0h exp 0", i, ifa.o_cpu_en); end
        end
        send_byte(1'b0, 8'h05);
        checks++; if (ifa.o_cpu_en !== 1'b0) begin errors++; $display("FAIL step_other_byte got %0h exp 0", ifa.o_cpu_en); end
        tick();
        ifa.i_rx_data    = 8'h02;
        ifa.i_rx_done    = 1'b1;
        ifa.i_cpu_halted = 1'b1;
        tick();
        ifa.i_rx_done = 1'b0;
        checks++; if (ifa.o_cpu_en !== 1'b0) begin errors++; $display("FAIL step_halt_en got %0h exp 0", ifa.o_cpu_en); end
        checks++; if (ifa.o_state !== 3'd5) begin errors++; $display("FAIL step_halt_state got %0h exp 5", ifa.o_state); end
        tick();
        ifa.i_cpu_halted = 1'b0;
        checks++; if (en_cnt_a - e0 !== 3) begin errors++; $display("FAIL step_pulse_count got %0d exp 3", en_cnt_a - e0); end
    endtask

    task automatic test_reset_mid_word();
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h20);
        send_byte(1'b0, 8'h01);
        rst_n = 1'b0;
        #2;
        checks++; if (ifa.o_state !== 3'd0) begin errors++; $display("FAIL midrst_state got %0h exp 0", ifa.o_state); end
        checks++; if (ifa.o_imem_data !== 32'h0) begin errors++; $display("FAIL midrst_data got %0h exp 0", ifa.o_imem_data); end
        checks++; if ({ifa.o_imem_we, ifa.o_cpu_en, ifa.o_load_done, ifa.o_err_ovf} !== 4'h0) begin errors++; $display("FAIL midrst_flags got %0h exp 0", {ifa.o_imem_we, ifa.o_cpu_en, ifa.o_load_done, ifa.o_err_ovf}); end
        tick();
        tick();
        rst_n = 1'b1;
        send_byte(1'b0, 8'h01);
        send_word(1'b0, 32'h11223344);
        checks++; if (ifa.o_imem_we !== 1'b1) begin errors++; $display("FAIL midrst_we got %0h exp 1", ifa.o_imem_we); end
        checks++; if (ifa.o_imem_addr !== 8'h00) begin errors++; $display("FAIL midrst_addr got %0h exp 0", ifa.o_imem_addr); end
        checks++; if (ifa.o_imem_data !== 32'h11223344) begin errors++; $display("FAIL midrst_word got %0h exp 11223344", ifa.o_imem_data); end
    endtask

    task automatic test_idle_ignore();
        logic [7:0] junk [3];
        int w0;
        junk = '{8'h04, 8'h02, 8'hFF};
        pulse_reset();
        w0 = we_cnt_a;
        for (int i = 0; i < 3; i++) begin
            send_byte(1'b0, junk[i]);
            checks++; if (ifa.o_cpu_en !== 1'b0) begin errors++; $display("FAIL idle_en[%0d] got %0h exp 0", i, ifa.o_cpu_en); end
            checks++; if (ifa.o_state !== 3'd0) begin errors++; $display("FAIL idle_state[%0d] got %0h exp 0", i, ifa.o_state); end
        end
        tick();
        checks++; if (we_cnt_a - w0 !== 0) begin errors++; $display("FAIL idle_writes got %0d exp 0", we_cnt_a - w0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [8];
        bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        send_byte(1'b0, 8'h01);
        tick();
        for (int i = 0; i < 8; i++) begin
            ifa.i_rx_data = bytes[i];
            ifa.i_rx_done = 1'b1;
            tick();
            if (i == 3) begin
                checks++; if (ifa.o_imem_we !== 1'b1) begin errors++; $display("FAIL b2b_we0 got %0h exp 1", ifa.o_imem_we); end
                checks++; if (ifa.o_imem_data !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_data0 got %0h exp deadbeef", ifa.o_imem_data); end
            end
            if (i == 7) begin
                checks++; if (ifa.o_imem_we !== 1'b1) begin errors++; $display("FAIL b2b_we1 got %0h exp 1", ifa.o_imem_we); end
                checks++; if (ifa.o_imem_addr !== 8'h01) begin errors++; $display("FAIL b2b_addr1 got %0h exp 1", ifa.o_imem_addr); end
                checks++; if (ifa.o_imem_data !== 32'hCAFEBABE) begin errors++; $display("FAIL b2b_data1 got %0h exp cafebabe", ifa.o_imem_data); end
            end
        end
        ifa.i_rx_done = 1'b0;
    endtask

    task automatic test_overflow();
        send_byte(1'b1, 8'h01);
        for (int i = 0; i < 4; i++) begin
            send_word(1'b1, 32'h00000010 + 32'(i));
            checks++; if (ifb.o_imem_addr !== 2'(i)) begin errors++; $display("FAIL ovf_addr[%0d] got %0h exp %0h", i, ifb.o_imem_addr, i); end
            checks++; if (ifb.o_imem_data !== 32'h00000010 + 32'(i)) begin errors++; $display("FAIL ovf_data[%0d] got %0h exp %0h", i, ifb.o_imem_data, 32'h10 + i); end
            checks++; if (ifb.o_load_done !== 1'b0) begin errors++; $display("FAIL ovf_load_done[%0d] got %0h exp 0", i, ifb.o_load_done); end
            checks++; if (ifb.o_err_ovf !== (i == 3)) begin errors++; $display("FAIL ovf_flag[%0d] got %0h exp %0h", i, ifb.o_err_ovf, (i == 3)); end
        end
        checks++; if (ifb.o_state !== 3'd2) begin errors++; $display("FAIL ovf_state got %0h exp 2", ifb.o_state); end
        send_byte(1'b1, 8'h04);
        checks++; if (ifb.o_state !== 3'd3) begin errors++; $display("FAIL ovf_run_state got %0h exp 3", ifb.o_state); end
        ifb.i_cpu_halted = 1'b1;
        tick();
        ifb.i_cpu_halted = 1'b0;
        checks++; if (ifb.o_err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0h exp 1", ifb.o_err_ovf); end
        checks++; if (ifb.o_state !== 3'd5) begin errors++; $display("FAIL ovf_done_state got %0h exp 5", ifb.o_state); end
        send_byte(1'b1, 8'h01);
        checks++; if (ifb.o_err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0h exp 0", ifb.o_err_ovf); end
        send_word(1'b1, 32'hAABBCCDD);
        checks++; if (ifb.o_imem_we !== 1'b1) begin errors++; $display("FAIL ovf_rewrite_we got %0h exp 1", ifb.o_imem_we); end
        checks++; if (ifb.o_imem_addr !== 2'd0) begin errors++; $display("FAIL ovf_rewrite_addr got %0h exp 0", ifb.o_imem_addr); end
        checks++; if (ifb.o_imem_data !== 32'hAABBCCDD) begin errors++; $display("FAIL ovf_rewrite_data got %0h exp aabbccdd", ifb.o_imem_data); end
    endtask

    initial begin
        ifa.i_rx_data = '0; ifa.i_rx_done = 1'b0; ifa.i_cpu_halted = 1'b0;
        ifb.i_rx_data = '0; ifb.i_rx_done = 1'b0; ifb.i_cpu_halted = 1'b0;
        test_reset();
        test_load();
        test_run();
        test_step();
        test_reset_mid_word();
        test_idle_ignore();
        test_back_to_back();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
